// File: rtl/id_char_tx.sv
// Token buffer + char-stream transmitter: start -> chars after 1..N edges, TERM after N+1, idle 8'h00 after.
// No backpressure: wr_en/start ignored while busy, writes dropped when full. Optional is_id check via ID_CHECK_EN.
module id_char_tx #(
  parameter int          DEPTH = 16,
  parameter int          AW    = 4,
  parameter logic [7:0]  TERM  = 8'h20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_char,
  input  logic          start,
  output logic [7:0]    char,
  output logic          char_valid,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic [AW:0]   count
`ifdef ID_CHECK_EN
  ,
  output logic          is_id
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_TERM} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    char_q, char_d;
  logic          char_valid_q, char_valid_d;
  logic          done_q, done_d;
  logic [7:0]    mem_q [DEPTH];
  logic          mem_we;
  logic [7:0]    rd_char;
  logic          last_char;

  assign full      = (count_q == DEPTH_C);
  assign rd_char   = mem_q[rptr_q];
  assign last_char = ({1'b0, rptr_q} == (count_q - ONE_C));

  always_comb begin
    state_d      = state_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    char_d       = 8'h00;
    char_valid_d = 1'b0;
    done_d       = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start wins over a same-cycle write only when there is something to send
        if (start && (count_q != '0)) begin
          state_d = ST_SEND;
          rptr_d  = '0;
        end else if (wr_en && !full) begin
          mem_we  = 1'b1;
          count_d = count_q + ONE_C;
        end
      end
      ST_SEND: begin
        char_d       = rd_char;
        char_valid_d = 1'b1;
        rptr_d       = rptr_q + AW'(1);
        if (last_char) state_d = ST_TERM;
      end
      ST_TERM: begin
        char_d       = TERM;
        char_valid_d = 1'b1;
        done_d       = 1'b1;
        count_d      = '0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rptr_q       <= '0;
      count_q      <= '0;
      char_q       <= 8'h00;
      char_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      done_q       <= done_d;
    end
  end

  // Storage has no reset; count alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[AW-1:0]] <= wr_char;
  end

  assign char       = char_q;
  assign char_valid = char_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign count      = count_q;

`ifdef ID_CHECK_EN
  logic id_ok_q, id_ok_d;
  logic is_id_q, is_id_d;

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  always_comb begin
    id_ok_d = id_ok_q;
    is_id_d = 1'b0;
    case (state_q)
      ST_IDLE: if (start && (count_q != '0)) id_ok_d = 1'b1;
      ST_SEND: id_ok_d = id_ok_q &&
                         ((rptr_q == '0) ? is_alpha(rd_char)
                                         : (is_alpha(rd_char) || is_digit(rd_char)));
      ST_TERM: is_id_d = id_ok_q;
      default: id_ok_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ok_q <= 1'b0;
      is_id_q <= 1'b0;
    end else begin
      id_ok_q <= id_ok_d;
      is_id_q <= is_id_d;
    end
  end

  assign is_id = is_id_q;
`endif

endmodule

// File: tb/tb_id_char_tx.sv
// Directed bench for id_char_tx: a vector table for the basic token flow plus hand sequences for corner cases.
module tb_id_char_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_char = 8'h00;
  logic       start = 1'b0;
  logic [7:0] char;
  logic       char_valid, busy, done, full;
  logic [4:0] count;
`ifdef ID_CHECK_EN
  logic       is_id;
`endif

  id_char_tx #(.DEPTH(16), .AW(4), .TERM(8'h20)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_char    (wr_char),
    .start      (start),
    .char       (char),
    .char_valid (char_valid),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .count      (count)
`ifdef ID_CHECK_EN
    ,
    .is_id      (is_id)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [7:0] tok [16];
  int tok_n = 0;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] wc;
    logic       st;
    logic [7:0] ech;
    logic       evld;
    logic       edone;
    logic       ebusy;
    logic [4:0] ecnt;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] c, input logic s);
    reset = r; wr_en = w; wr_char = c; start = s;
    @(posedge clk);
    #1;
  endtask

  task automatic load_tok();
    for (int i = 0; i < tok_n; i++) begin
      step(1'b0, 1'b1, tok[i], 1'b0);
      chk("load_valid", char_valid, 1'b0);
      chk("load_char", char, 8'h00);
    end
  endtask

  task automatic send_tok(input logic sw, input logic [7:0] sc, input logic exp_id);
    step(1'b0, sw, sc, 1'b1);
    chk("start_busy", busy, 1'b1);
    chk("start_count", count, tok_n);
    for (int i = 0; i < tok_n; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("send_char", char, tok[i]);
      chk("send_valid", char_valid, 1'b1);
      chk("send_done", done, 1'b0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("term_char", char, 8'h20);
    chk("term_valid", char_valid, 1'b1);
    chk("term_done", done, 1'b1);
    chk("term_count", count, 0);
`ifdef ID_CHECK_EN
    chk("term_is_id", is_id, exp_id);
`else
    if (exp_id !== 1'b0 && exp_id !== 1'b1) $display("note: exp_id unknown");
`endif
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("idle_char", char, 8'h00);
    chk("idle_valid", char_valid, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
`ifdef ID_CHECK_EN
    chk("idle_is_id", is_id, 1'b0);
`endif
  endtask

  initial begin
    //         rst wr  wc     st  ech    vld don bsy cnt
    vt[0]  = '{1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 5'd0};
    vt[1]  = '{0, 1, 8'h41, 0, 8'h00, 0, 0, 0, 5'd1};
    vt[2]  = '{0, 1, 8'h61, 0, 8'h00, 0, 0, 0, 5'd2};
    vt[3]  = '{0, 1, 8'h30, 0, 8'h00, 0, 0, 0, 5'd3};
    vt[4]  = '{0, 1, 8'h39, 0, 8'h00, 0, 0, 0, 5'd4};
    vt[5]  = '{0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 5'd4};
    vt[6]  = '{0, 0, 8'h00, 0, 8'h41, 1, 0, 1, 5'd4};
    vt[7]  = '{0, 1, 8'h24, 1, 8'h61, 1, 0, 1, 5'd4};
    vt[8]  = '{0, 0, 8'h00, 0, 8'h30, 1, 0, 1, 5'd4};
    vt[9]  = '{0, 1, 8'h7A, 0, 8'h39, 1, 0, 1, 5'd4};
    vt[10] = '{0, 0, 8'h00, 0, 8'h20, 1, 1, 0, 5'd0};
    vt[11] = '{0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 5'd0};
    vt[12] = '{0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 5'd0};
    vt[13] = '{0, 1, 8'h75, 1, 8'h00, 0, 0, 0, 5'd1};
    vt[14] = '{0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 5'd1};
    vt[15] = '{0, 0, 8'h00, 0, 8'h75, 1, 0, 1, 5'd1};
    vt[16] = '{0, 0, 8'h00, 0, 8'h20, 1, 1, 0, 5'd0};
    vt[17] = '{0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 5'd0};

    for (int i = 0; i < 18; i++) begin
      step(vt[i].rst, vt[i].wr, vt[i].wc, vt[i].st);
      chk($sformatf("vec%0d_char", i), char, vt[i].ech);
      chk($sformatf("vec%0d_valid", i), char_valid, vt[i].evld);
      chk($sformatf("vec%0d_done", i), done, vt[i].edone);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].ebusy);
      chk($sformatf("vec%0d_count", i), count, vt[i].ecnt);
    end
    chk("reset_full", full, 1'b0);

    // Fill to capacity, then an overflow write must be dropped.
    tok_n = 16;
    for (int i = 0; i < 16; i++) tok[i] = 8'h41 + 8'(i);
    load_tok();
    chk("full_flag", full, 1'b1);
    chk("full_count", count, 16);
    step(1'b0, 1'b1, 8'h24, 1'b0);
    chk("drop_count", count, 16);
    chk("drop_full", full, 1'b1);
    send_tok(1'b0, 8'h00, 1'b1);
    chk("after_full", full, 1'b0);

    // start with a same-cycle write: write must not be stored.
    tok_n = 2; tok[0] = 8'h78; tok[1] = 8'h79;
    load_tok();
    send_tok(1'b1, 8'h75, 1'b1);

    // Reset during the second SEND cycle aborts with no TERM/done.
    tok_n = 2; tok[0] = 8'h75; tok[1] = 8'h35;
    load_tok();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("abort_first_char", char, 8'h75);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("abort_char", char, 8'h00);
    chk("abort_valid", char_valid, 1'b0);
    chk("abort_count", count, 0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("abort_no_done", done, 1'b0);
      chk("abort_no_valid", char_valid, 1'b0);
    end

    // Back-to-back tokens separated by idle cycles.
    tok_n = 2; tok[0] = 8'h61; tok[1] = 8'h62;
    load_tok();
    send_tok(1'b0, 8'h00, 1'b1);
    tok_n = 1; tok[0] = 8'h63;
    load_tok();
    send_tok(1'b0, 8'h00, 1'b1);

    // Identifier check tokens, plus 8'h00/TERM sent verbatim.
    tok_n = 2; tok[0] = 8'h61; tok[1] = 8'h39;
    load_tok(); send_tok(1'b0, 8'h00, 1'b1);
    tok[0] = 8'h39; tok[1] = 8'h61;
    load_tok(); send_tok(1'b0, 8'h00, 1'b0);
    tok[0] = 8'h24; tok[1] = 8'h75;
    load_tok(); send_tok(1'b0, 8'h00, 1'b0);
    tok[0] = 8'h00; tok[1] = 8'h20;
    load_tok(); send_tok(1'b0, 8'h00, 1'b0);
    tok_n = 3; tok[0] = 8'h5A; tok[1] = 8'h7A; tok[2] = 8'h2F;
    load_tok(); send_tok(1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
